mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between instruction fetch (IF) and data access (DM) in the pipelined hart.
- Holds one outstanding transaction at a time.
- Fixed priority to DM, with a streak limiter so IF is not starved.
- Uses valid/ready request handshakes and a one-cycle response pulse to the owning requester. The memory side may take any number of cycles to accept a request or to return read data.

Parameters:
- ADDR_BITS, 64, address width (DWORD).
- DATA_BITS, 64, data width (DWORD).
- MAX_DM_STREAK, 4, maximum number of consecutive DM grants while IF is waiting; must be at least 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- if_req_valid  in  1  fetch request.
- if_req_addr  in  ADDR_BITS  fetch PC.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_rsp_valid  out  1  one-cycle pulse; if_rsp_data is valid.
- if_rsp_data  out  32  instruction, equal to mem_rsp_data[31:0].
- dm_req_valid  in  1  data request.
- dm_req_we  in  1  1 = store, 0 = load.
- dm_req_addr  in  ADDR_BITS  data address.
- dm_req_funct3  in  3  access size/sign (RISC-V funct3).
- dm_req_wdata  in  DATA_BITS  store data.
- dm_req_ready  out  1  data request accepted this cycle.
- dm_rsp_valid  out  1  one-cycle pulse; load data valid, or store complete.
- dm_rsp_data  out  DATA_BITS  load data; 0 for stores.
- mem_req_valid  out  1  request to memory.
- mem_req_we, mem_req_addr, mem_req_funct3, mem_req_wdata  out  1/ADDR_BITS/3/DATA_BITS  registered request fields.
- mem_req_ready  in  1  memory accepts the request.
- mem_rsp_valid  in  1  read data valid.
- mem_rsp_data  in  DATA_BITS  read data.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- States: IDLE, REQ, RSP. On reset the FSM enters IDLE.
- Reset values: every output, the owner flag, the request registers and the streak counter are 0.
- IDLE:
  - Grant is combinational. DM wins when dm_req_valid is high, unless if_req_valid is high and streak == MAX_DM_STREAK; in that case IF wins.
  - Only the winner sees its ready asserted. Ready is never asserted outside IDLE.
  - On valid&&ready: latch the owner and the request, then go to REQ.
  - IF requests are latched with we=0, funct3=3'b010, wdata=0.
- Streak counter:
  - On a DM grant while if_req_valid is high: streak <= streak+1, saturating at MAX_DM_STREAK.
  - On an IF grant, or on any cycle in IDLE with if_req_valid low: streak <= 0.
- REQ:
  - mem_req_valid=1 and the mem_req_* outputs come from the registers. They hold stable until mem_req_ready.
  - mem_req_ready with we=1: go to IDLE and pulse dm_rsp_valid with dm_rsp_data=0 on the next cycle.
  - mem_req_ready with we=0: go to RSP.
- RSP:
  - mem_req_valid=0.
  - On mem_rsp_valid: register the data and pulse the owner's rsp_valid for exactly one cycle (the cycle after mem_rsp_valid), then go to IDLE.
  - A new grant may be accepted in IDLE during that pulse cycle.
- Latency: accept at cycle T, mem_req_valid at T+1. With zero-wait memory (ready and rsp in the same cycle as asserted), a load completes with rsp_valid at T+3.
- mem_rsp_valid in IDLE or REQ is ignored; it must not generate a response.
- Requester inputs are not sampled outside IDLE.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately (asynchronously) and the pending response is dropped. No rsp_valid is issued for it, and a later mem_rsp_valid is ignored.
- At most one rsp_valid is active in any cycle; if_rsp_valid and dm_rsp_valid are never high together.

Test Plan:
- Single IF read: if_req_valid=1, addr=0x100; memory ready at once and returns 0x00A00093 two cycles later -> if_req_ready cycle 0, mem_req_valid cycle 1 with addr 0x100 and funct3=010, if_rsp_valid for one cycle with data 0x00A00093.
- Simultaneous requests: IF and DM valid together, DM load addr 0x2000 -> DM granted first; IF granted in the next IDLE cycle after the DM response; the two responses go to the correct owners.
- Starvation guard with MAX_DM_STREAK=4: IF and DM valid continuously -> grant order DM, DM, DM, DM, IF, DM…; streak returns to 0 after the IF grant.
- Store: dm_req_we=1, addr 0x3000, wdata 0xDEADBEEF, mem_req_ready delayed 3 cycles -> mem_req fields stable for 3 cycles, then dm_rsp_valid pulse with data 0 one cycle after acceptance, and no RSP state.
- Back-pressure and spurious response: mem_rsp_valid pulses while in REQ -> ignored; a later real response is delivered exactly once.
- Reset in RSP: assert reset while waiting for read data, then deliver mem_rsp_valid after reset releases -> no rsp_valid, FSM in IDLE, all outputs 0, busy 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: IF and DM requester handshakes plus the memory-side port.
// The arbiter takes the slave modport; the requesters/memory environment takes master.
interface mem_port_arbiter_if #(
    parameter int ADDR_BITS = 64,
    parameter int DATA_BITS = 64
);
    logic                 if_req_valid;
    logic [ADDR_BITS-1:0] if_req_addr;
    logic                 if_req_ready;
    logic                 if_rsp_valid;
    logic [31:0]          if_rsp_data;

    logic                 dm_req_valid;
    logic                 dm_req_we;
    logic [ADDR_BITS-1:0] dm_req_addr;
    logic [2:0]           dm_req_funct3;
    logic [DATA_BITS-1:0] dm_req_wdata;
    logic                 dm_req_ready;
    logic                 dm_rsp_valid;
    logic [DATA_BITS-1:0] dm_rsp_data;

    logic                 mem_req_valid;
    logic                 mem_req_we;
    logic [ADDR_BITS-1:0] mem_req_addr;
    logic [2:0]           mem_req_funct3;
    logic [DATA_BITS-1:0] mem_req_wdata;
    logic                 mem_req_ready;
    logic                 mem_rsp_valid;
    logic [DATA_BITS-1:0] mem_rsp_data;

    logic                 busy;

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        input  dm_req_valid, dm_req_we, dm_req_addr, dm_req_funct3, dm_req_wdata,
        output dm_req_ready, dm_rsp_valid, dm_rsp_data,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_funct3, mem_req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output busy
    );

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        output dm_req_valid, dm_req_we, dm_req_addr, dm_req_funct3, dm_req_wdata,
        input  dm_req_ready, dm_rsp_valid, dm_rsp_data,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_funct3, mem_req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access, one
// transaction in flight, DM priority with a streak limit so fetch cannot starve.
module mem_port_arbiter #(
    parameter int ADDR_BITS     = 64,
    parameter int DATA_BITS     = 64,
    parameter int MAX_DM_STREAK = 4
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam int STREAK_BITS = $clog2(MAX_DM_STREAK + 1);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t               state_q, state_d;
    logic                 owner_q;
    logic                 we_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [2:0]           funct3_q;
    logic [DATA_BITS-1:0] wdata_q;
    logic [STREAK_BITS-1:0] streak_q;
    logic                 if_rsp_q;
    logic                 dm_rsp_q;
    logic [DATA_BITS-1:0] rsp_data_q;
    logic                 streak_full;
    logic                 if_grant;
    logic                 dm_grant;

    assign streak_full = (streak_q == STREAK_BITS'(MAX_DM_STREAK));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A grant is only ever offered to a requester that is already valid, so ready implies the handshake.
    always_comb begin
        state_d  = state_q;
        if_grant = 1'b0;
        dm_grant = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.if_req_valid && (!bus.dm_req_valid || streak_full)) if_grant = 1'b1;
                else if (bus.dm_req_valid)                                  dm_grant = 1'b1;
                if (if_grant || dm_grant) state_d = REQ;
            end
            REQ: begin
                if (bus.mem_req_ready) state_d = we_q ? IDLE : RSP;
            end
            RSP: begin
                if (bus.mem_rsp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            funct3_q   <= '0;
            wdata_q    <= '0;
            streak_q   <= '0;
            if_rsp_q   <= 1'b0;
            dm_rsp_q   <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            if_rsp_q <= 1'b0;
            dm_rsp_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (if_grant) begin
                        owner_q  <= 1'b0;
                        we_q     <= 1'b0;
                        addr_q   <= bus.if_req_addr;
                        funct3_q <= 3'b010;
                        wdata_q  <= '0;
                        streak_q <= '0;
                    end else if (dm_grant) begin
                        owner_q  <= 1'b1;
                        we_q     <= bus.dm_req_we;
                        addr_q   <= bus.dm_req_addr;
                        funct3_q <= bus.dm_req_funct3;
                        wdata_q  <= bus.dm_req_wdata;
                        if (!bus.if_req_valid) streak_q <= '0;
                        else if (!streak_full) streak_q <= streak_q + STREAK_BITS'(1);
                    end else begin
                        streak_q <= '0;
                    end
                end
                REQ: begin
                    // Stores complete on acceptance; the memory returns nothing for them.
                    if (bus.mem_req_ready && we_q) begin
                        dm_rsp_q   <= 1'b1;
                        rsp_data_q <= '0;
                    end
                end
                RSP: begin
                    if (bus.mem_rsp_valid) begin
                        rsp_data_q <= bus.mem_rsp_data;
                        if (owner_q) dm_rsp_q <= 1'b1;
                        else         if_rsp_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.if_req_ready   = if_grant;
    assign bus.dm_req_ready   = dm_grant;
    assign bus.if_rsp_valid   = if_rsp_q;
    assign bus.if_rsp_data    = rsp_data_q[31:0];
    assign bus.dm_rsp_valid   = dm_rsp_q;
    assign bus.dm_rsp_data    = rsp_data_q;
    assign bus.mem_req_valid  = (state_q == REQ);
    assign bus.mem_req_we     = we_q;
    assign bus.mem_req_addr   = addr_q;
    assign bus.mem_req_funct3 = funct3_q;
    assign bus.mem_req_wdata  = wdata_q;
    assign bus.busy           = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester drivers and a memory model feed the DUT,
// expected grants/memory requests/responses are queued by the stimulus and popped by a monitor.
module tb_mem_port_arbiter;
    localparam int AB   = 64;
    localparam int DB   = 64;
    localparam int MAXS = 4;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [2:0]  f3;
        logic [63:0] wdata;
    } mreq_t;

    typedef struct {
        bit          dm;
        logic [63:0] data;
        int          lat;
    } rsp_t;

    logic clk = 1'b0;
    logic reset;

    mem_port_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

    mem_port_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .MAX_DM_STREAK(MAXS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    mreq_t if_pend[$];
    mreq_t dm_pend[$];
    mreq_t exp_mem[$];
    rsp_t  exp_rsp[$];
    bit    exp_grant[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int ready_delay = 0;
    int rsp_delay   = 0;
    bit spurious_en = 1'b0;
    bit hold_rsp    = 1'b0;
    int inject_req  = 0;
    logic [63:0] mem_data [logic [63:0]];
    logic [63:0] streak_data [6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit dm, input logic we, input logic [63:0] addr,
                                 input logic [2:0] f3, input logic [63:0] wdata);
        mreq_t m;
        m.we = we; m.addr = addr; m.f3 = f3; m.wdata = wdata;
        if (dm) dm_pend.push_back(m);
        else    if_pend.push_back(m);
    endtask

    task automatic expectTxn(input bit dm, input logic we, input logic [63:0] addr, input logic [2:0] f3,
                             input logic [63:0] wdata, input logic [63:0] rdata, input int lat,
                             input bit has_rsp);
        mreq_t m;
        rsp_t  r;
        exp_grant.push_back(dm);
        m.we = we; m.addr = addr; m.f3 = f3; m.wdata = wdata;
        exp_mem.push_back(m);
        if (has_rsp) begin
            r.dm = dm; r.data = we ? 64'h0 : rdata; r.lat = lat;
            exp_rsp.push_back(r);
        end
    endtask

    function automatic logic [255:0] allOut();
        return 256'({bus.if_req_ready, bus.if_rsp_valid, bus.if_rsp_data, bus.dm_req_ready,
                     bus.dm_rsp_valid, bus.dm_rsp_data, bus.mem_req_valid, bus.mem_req_we,
                     bus.mem_req_addr, bus.mem_req_funct3, bus.mem_req_wdata, bus.busy});
    endfunction

    task automatic waitDrain(input string name, input int maxc);
        int n = 0;
        while ((exp_rsp.size() > 0 || exp_grant.size() > 0 || exp_mem.size() > 0 ||
                if_pend.size() > 0 || dm_pend.size() > 0) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= maxc) begin
            errors++;
            $display("[TB] FAIL %s_timeout: got %0d responses outstanding after %0d cycles, required 0",
                     name, exp_rsp.size(), maxc);
        end
        repeat (2) @(negedge clk);
    endtask

    // Requesters hold valid with the head of their queue until the handshake is seen.
    initial begin : req_driver
        bit if_hs;
        bit dm_hs;
        bus.if_req_valid = 1'b0; bus.if_req_addr = '0;
        bus.dm_req_valid = 1'b0; bus.dm_req_we = 1'b0; bus.dm_req_addr = '0;
        bus.dm_req_funct3 = '0;  bus.dm_req_wdata = '0;
        forever begin
            @(negedge clk);
            if_hs = bus.if_req_valid && bus.if_req_ready;
            dm_hs = bus.dm_req_valid && bus.dm_req_ready;
            @(posedge clk);
            #1;
            if (if_hs && if_pend.size() > 0) void'(if_pend.pop_front());
            if (dm_hs && dm_pend.size() > 0) void'(dm_pend.pop_front());
            if (if_pend.size() > 0) begin
                bus.if_req_valid = 1'b1; bus.if_req_addr = if_pend[0].addr;
            end else begin
                bus.if_req_valid = 1'b0; bus.if_req_addr = '0;
            end
            if (dm_pend.size() > 0) begin
                bus.dm_req_valid = 1'b1; bus.dm_req_we = dm_pend[0].we; bus.dm_req_addr = dm_pend[0].addr;
                bus.dm_req_funct3 = dm_pend[0].f3; bus.dm_req_wdata = dm_pend[0].wdata;
            end else begin
                bus.dm_req_valid = 1'b0; bus.dm_req_we = 1'b0; bus.dm_req_addr = '0;
                bus.dm_req_funct3 = '0;  bus.dm_req_wdata = '0;
            end
        end
    end

    // Memory model: configurable accept delay and read delay, optional junk responses outside RSP.
    initial begin : mem_model
        int mstate;
        int cnt;
        int seen;
        bit acc;
        logic we_l;
        logic [63:0] addr_l;
        mstate = 0; cnt = 0; seen = 0; we_l = 1'b0; addr_l = '0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
            acc = 1'b0;
            if (reset) begin
                mstate = 0;
                seen = inject_req;
            end else begin
                if (inject_req != seen) begin
                    seen = inject_req;
                    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 64'h5555_AAAA_5555_AAAA;
                end else if (spurious_en && mstate != 2) begin
                    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 64'hBAD0_BAD0_BAD0_BAD0;
                end
                case (mstate)
                    0: if (bus.mem_req_valid) begin
                        we_l = bus.mem_req_we; addr_l = bus.mem_req_addr;
                        if (ready_delay == 0) acc = 1'b1;
                        else begin cnt = ready_delay; mstate = 1; end
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) acc = 1'b1;
                    end
                    2: if (!hold_rsp) begin
                        if (cnt == 0) begin
                            bus.mem_rsp_valid = 1'b1;
                            bus.mem_rsp_data = mem_data.exists(addr_l) ? mem_data[addr_l] : 64'h0;
                            mstate = 0;
                        end else cnt--;
                    end
                    default: mstate = 0;
                endcase
                if (acc) begin
                    bus.mem_req_ready = 1'b1;
                    if (we_l) mstate = 0;
                    else begin mstate = 2; cnt = rsp_delay; end
                end
            end
        end
    end

    // Monitor: responses before grants, so a grant in a response cycle starts a fresh latency count.
    initial begin : monitor
        rsp_t  r;
        mreq_t m;
        int    grant_cyc;
        grant_cyc = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.if_rsp_valid || bus.dm_rsp_valid) begin
                    checkOutput("rsp_exclusive", 256'(bus.if_rsp_valid & bus.dm_rsp_valid), 256'(1'b0));
                    if (exp_rsp.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL unexpected_rsp: got if_rsp_valid=%0b dm_rsp_valid=%0b, required no response",
                                 bus.if_rsp_valid, bus.dm_rsp_valid);
                    end else begin
                        r = exp_rsp.pop_front();
                        checkOutput("rsp_owner_dm", 256'(bus.dm_rsp_valid), 256'(r.dm));
                        if (r.dm) checkOutput("dm_rsp_data", 256'(bus.dm_rsp_data), 256'(r.data));
                        else      checkOutput("if_rsp_data", 256'(bus.if_rsp_data), 256'(r.data[31:0]));
                        if (r.lat >= 0) checkOutput("rsp_latency", 256'(cyc - grant_cyc), 256'(r.lat));
                    end
                end
                if (bus.if_req_ready || bus.dm_req_ready) begin
                    checkOutput("ready_only_one_in_idle",
                                256'({bus.if_req_ready & bus.dm_req_ready, bus.busy}), 256'(2'b00));
                    if (exp_grant.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL unexpected_grant: got if_ready=%0b dm_ready=%0b, required no grant",
                                 bus.if_req_ready, bus.dm_req_ready);
                    end else begin
                        checkOutput("grant_owner_dm", 256'(bus.dm_req_ready), 256'(exp_grant.pop_front()));
                    end
                    grant_cyc = cyc;
                end
                if (bus.mem_req_valid) begin
                    if (exp_mem.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL unexpected_mem_req: got addr=%0h, required no request", bus.mem_req_addr);
                    end else begin
                        m = exp_mem[0];
                        checkOutput("mem_req_fields",
                                    256'({bus.mem_req_we, bus.mem_req_addr, bus.mem_req_funct3, bus.mem_req_wdata}),
                                    256'({m.we, m.addr, m.f3, m.wdata}));
                        if (bus.mem_req_ready) void'(exp_mem.pop_front());
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        reset = 1'b1;
        mem_data[64'h100]  = 64'hCAFE_F00D_00A0_0093;
        mem_data[64'h104]  = 64'h1234_5678_00C1_0113;
        mem_data[64'h108]  = 64'hFFFF_0000_0020_8093;
        mem_data[64'h10C]  = 64'h0000_FFFF_0031_0193;
        mem_data[64'h2000] = 64'h1122_3344_5566_7788;
        mem_data[64'h2008] = 64'h8877_6655_4433_2211;
        mem_data[64'h5000] = 64'h0F0F_0F0F_F0F0_F0F0;
        streak_data[0] = 64'hA0A0_0000_0000_0001;
        streak_data[1] = 64'hA1A1_0000_0000_0002;
        streak_data[2] = 64'hA2A2_0000_0000_0003;
        streak_data[3] = 64'hA3A3_0000_0000_0004;
        streak_data[4] = 64'hA4A4_0000_0000_0005;
        streak_data[5] = 64'hA5A5_0000_0000_0006;
        for (int i = 0; i < 6; i++) mem_data[64'h4000 + 64'(8 * i)] = streak_data[i];

        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", allOut(), 256'(0));
        checkOutput("reset_busy", 256'(bus.busy), 256'(1'b0));
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] single IF read");
        applyStimulus(1'b0, 1'b0, 64'h100, 3'b010, 64'h0);
        expectTxn(1'b0, 1'b0, 64'h100, 3'b010, 64'h0, 64'h0000_0000_00A0_0093, 3, 1'b1);
        waitDrain("if_read", 40);

        $display("[TB] simultaneous IF and DM");
        applyStimulus(1'b1, 1'b0, 64'h2000, 3'b011, 64'h0);
        applyStimulus(1'b0, 1'b0, 64'h104, 3'b010, 64'h0);
        expectTxn(1'b1, 1'b0, 64'h2000, 3'b011, 64'h0, 64'h1122_3344_5566_7788, 3, 1'b1);
        expectTxn(1'b0, 1'b0, 64'h104, 3'b010, 64'h0, 64'h0000_0000_00C1_0113, 3, 1'b1);
        waitDrain("simultaneous", 60);

        $display("[TB] starvation guard");
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 64'h4000 + 64'(8 * i), 3'b011, 64'h0);
        applyStimulus(1'b0, 1'b0, 64'h108, 3'b010, 64'h0);
        applyStimulus(1'b0, 1'b0, 64'h10C, 3'b010, 64'h0);
        for (int i = 0; i < 4; i++)
            expectTxn(1'b1, 1'b0, 64'h4000 + 64'(8 * i), 3'b011, 64'h0, streak_data[i], 3, 1'b1);
        expectTxn(1'b0, 1'b0, 64'h108, 3'b010, 64'h0, 64'h0000_0000_0020_8093, 3, 1'b1);
        for (int i = 4; i < 6; i++)
            expectTxn(1'b1, 1'b0, 64'h4000 + 64'(8 * i), 3'b011, 64'h0, streak_data[i], 3, 1'b1);
        expectTxn(1'b0, 1'b0, 64'h10C, 3'b010, 64'h0, 64'h0000_0000_0031_0193, 3, 1'b1);
        waitDrain("streak", 200);

        $display("[TB] delayed store");
        ready_delay = 3;
        applyStimulus(1'b1, 1'b1, 64'h3000, 3'b011, 64'h0000_0000_DEAD_BEEF);
        expectTxn(1'b1, 1'b1, 64'h3000, 3'b011, 64'h0000_0000_DEAD_BEEF, 64'h0, 5, 1'b1);
        waitDrain("store", 40);
        ready_delay = 0;

        $display("[TB] spurious memory responses");
        ready_delay = 2;
        rsp_delay   = 1;
        spurious_en = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 64'h2008, 3'b000, 64'h0);
        expectTxn(1'b1, 1'b0, 64'h2008, 3'b000, 64'h0, 64'h8877_6655_4433_2211, 6, 1'b1);
        waitDrain("spurious", 40);
        spurious_en = 1'b0;
        ready_delay = 0;
        rsp_delay   = 0;
        repeat (2) @(negedge clk);

        $display("[TB] reset while waiting for read data");
        hold_rsp = 1'b1;
        applyStimulus(1'b1, 1'b0, 64'h5000, 3'b011, 64'h0);
        expectTxn(1'b1, 1'b0, 64'h5000, 3'b011, 64'h0, 64'h0, -1, 1'b0);
        n = 0;
        while (!(bus.busy && !bus.mem_req_valid) && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached_rsp_state", 256'(n < 30), 256'(1'b1));
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_busy", 256'(bus.busy), 256'(1'b0));
        checkOutput("async_reset_outputs", allOut(), 256'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hold_rsp = 1'b0;
        repeat (2) @(negedge clk);
        inject_req++;
        repeat (4) @(negedge clk);
        checkOutput("post_reset_outputs", allOut(), 256'(0));

        $display("[TB] recovery IF read");
        applyStimulus(1'b0, 1'b0, 64'h100, 3'b010, 64'h0);
        expectTxn(1'b0, 1'b0, 64'h100, 3'b010, 64'h0, 64'h0000_0000_00A0_0093, 3, 1'b1);
        waitDrain("recovery", 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got no completion, required end of test");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
